// File: rtl/full_connect2_argmax.sv
// Second fully connected layer (128 -> 10) with argmax classifier.
// Shares the layer ROM and the 128-lane MultAdder with the first layer, so every row is fetched and reduced in turn.
module full_connect2_argmax #(
    parameter int          BIT    = 8,
    parameter int          ACC_W  = 2*BIT-1,
    parameter int          FRAC   = 7,
    parameter logic [10:0] W_BASE = 11'h408,
    parameter logic [10:0] B_BASE = 11'h412
) (
    input  logic                 clk,
    input  logic                 iRst_n,
    input  logic                 start,
    input  logic [128*BIT-1:0]   data_from_ram,
    input  logic [128*BIT-1:0]   data_from_rom,
    input  logic [ACC_W-1:0]     data_from_MultAdder,
    input  logic                 overflow_from_MultAdder,
    output logic [10:0]          addr_to_rom,
    output logic [128*BIT-1:0]   opr1_to_MultAdder,
    output logic [128*BIT-1:0]   opr2_to_MultAdder,
    output logic [3:0]           digit,
    output logic [ACC_W:0]       max_score,
    output logic                 overflow,
    output logic                 done
);

    localparam int         LANES    = 128;
    localparam int         CLASSES  = 10;
    localparam logic [3:0] LAST_ROW = 4'd9;

    typedef enum logic [2:0] {
        IDLE,
        REQ_BIAS,
        GET_BIAS,
        REQ_W,
        GET_W,
        GET_DOT,
        CMP,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [3:0]           row;
    logic [LANES*BIT-1:0] act;
    // Indexed directly by the 4-bit row counter; entries 10..15 are never loaded and stay 0.
    logic [BIT-1:0]       bias [16];
    logic [ACC_W-1:0]     dot;

    logic [BIT-1:0]       bias_sel;
    logic signed [ACC_W:0] dot_ext;
    logic signed [ACC_W:0] bias_ext;
    logic signed [ACC_W:0] score;
    logic                 better;

    always_ff @(posedge clk or negedge iRst_n) begin
        if (!iRst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = REQ_BIAS;
            REQ_BIAS: state_nxt = GET_BIAS;
            GET_BIAS: state_nxt = REQ_W;
            REQ_W:    state_nxt = GET_W;
            GET_W:    state_nxt = GET_DOT;
            GET_DOT:  state_nxt = CMP;
            CMP:      state_nxt = (row == LAST_ROW) ? DONE : REQ_W;
            DONE:     if (!start) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Bias is shifted into the dot-product fixed point; the sum wraps silently at ACC_W+1 bits.
    always_comb begin
        bias_sel = bias[row];
        dot_ext  = {dot[ACC_W-1], dot};
        bias_ext = {{(ACC_W+1-BIT){bias_sel[BIT-1]}}, bias_sel} <<< FRAC;
        score    = dot_ext + bias_ext;
        better   = (row == 4'd0) || (score > $signed(max_score));
    end

    always_ff @(posedge clk or negedge iRst_n) begin
        if (!iRst_n) begin
            row               <= '0;
            act               <= '0;
            dot               <= '0;
            addr_to_rom       <= '0;
            opr1_to_MultAdder <= '0;
            opr2_to_MultAdder <= '0;
            digit             <= '0;
            max_score         <= '0;
            overflow          <= 1'b0;
            done              <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                bias[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        act       <= data_from_ram;
                        overflow  <= 1'b0;
                        row       <= '0;
                        digit     <= '0;
                        max_score <= '0;
                    end
                end
                REQ_BIAS: begin
                    addr_to_rom <= B_BASE;
                end
                GET_BIAS: begin
                    for (int i = 0; i < CLASSES; i++) begin
                        bias[i] <= data_from_rom[BIT*i +: BIT];
                    end
                end
                REQ_W: begin
                    addr_to_rom <= W_BASE + {7'd0, row};
                end
                GET_W: begin
                    opr1_to_MultAdder <= act;
                    opr2_to_MultAdder <= data_from_rom;
                end
                GET_DOT: begin
                    dot      <= data_from_MultAdder;
                    overflow <= overflow | overflow_from_MultAdder;
                end
                // Strict compare keeps the lowest index on ties.
                CMP: begin
                    if (better) begin
                        max_score <= score;
                        digit     <= row;
                    end
                    if (row == LAST_ROW) begin
                        done <= 1'b1;
                    end else begin
                        row <= row + 4'd1;
                    end
                end
                DONE: begin
                    if (!start) begin
                        done <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
